// File: rtl/imem_arbiter_if.sv
// Requester-side handshake bundle for one port of the instruction-memory
// arbiter: request/address/size in, grant and registered response out.
interface imem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        word;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   // Requester drives the access, observes grant and response.
   modport master (
      output req, addr, word,
      input  gnt, rvalid, rdata, err
   );

   // Arbiter samples the access, returns grant and response.
   modport slave (
      input  req, addr, word,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port round-robin arbiter in front of the combinational instruction
// memory read port. Port 0 is instruction fetch, port 1 is debug readback.
// Grant is combinational; the range-checked, size-masked response is
// registered and returned to the granted port one cycle later.
module imem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   imem_arbiter_if.slave     m0,
   imem_arbiter_if.slave     m1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_word,
   input  logic [DATA_W-1:0] mem_data
);

   typedef struct packed {
      logic              valid;
      logic              err;
      logic [DATA_W-1:0] data;
   } resp_t;

   // last_q = index of the most recently granted port; 1 at reset so that
   // port 0 wins the first tie.
   logic  last_q, last_d;
   resp_t rsp0_q, rsp0_d;
   resp_t rsp1_q, rsp1_d;

   logic              gnt0, gnt1;
   logic [ADDR_W-1:0] sel_addr;
   logic [1:0]        sel_word;
   logic [ADDR_W:0]   last_byte;
   logic [ADDR_W:0]   end_addr;
   logic              range_err;
   logic [DATA_W-1:0] size_mask;
   logic [DATA_W-1:0] resp_data;

   // Arbitration, memory drive, range check and next response values.
   always_comb begin
      // NOTE: every signal gets a default at the top of the block so no path
      // leaves it unassigned -- otherwise synthesis infers a latch.
      gnt0      = m0.req & (~m1.req | last_q);
      gnt1      = m1.req & (~m0.req | ~last_q);
      last_d    = last_q;
      sel_addr  = '0;
      sel_word  = '0;
      rsp0_d    = rsp0_q;
      rsp1_d    = rsp1_q;
      last_byte = '0;
      size_mask = '0;

      if (gnt0) begin
         sel_addr = m0.addr;
         sel_word = m0.word;
         last_d   = 1'b0;
      end else if (gnt1) begin
         sel_addr = m1.addr;
         sel_word = m1.word;
         last_d   = 1'b1;
      end

      case (sel_word)
         2'b00: begin last_byte = (ADDR_W+1)'(0); size_mask = DATA_W'(64'h0000_0000_0000_00FF); end
         2'b01: begin last_byte = (ADDR_W+1)'(1); size_mask = DATA_W'(64'h0000_0000_0000_FFFF); end
         2'b10: begin last_byte = (ADDR_W+1)'(3); size_mask = DATA_W'(64'h0000_0000_FFFF_FFFF); end
         default: begin last_byte = (ADDR_W+1)'(7); size_mask = '1; end
      endcase

      // One extra bit catches any access whose last byte runs past the top.
      end_addr  = {1'b0, sel_addr} + last_byte;
      range_err = end_addr[ADDR_W];
      resp_data = range_err ? '0 : (mem_data & size_mask);

      // Pulse rvalid only toward the granted port; the other holds its data.
      rsp0_d.valid = 1'b0;
      rsp1_d.valid = 1'b0;
      if (gnt0) rsp0_d = '{valid: 1'b1, err: range_err, data: resp_data};
      if (gnt1) rsp1_d = '{valid: 1'b1, err: range_err, data: resp_data};
   end

   // Round-robin pointer and per-port response registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // the pre-edge value of its inputs regardless of statement order.
      if (rst) begin
         last_q <= 1'b1;
         rsp0_q <= '0;
         rsp1_q <= '0;
      end else begin
         last_q <= last_d;
         rsp0_q <= rsp0_d;
         rsp1_q <= rsp1_d;
      end
   end

   assign mem_addr  = sel_addr;
   assign mem_word  = sel_word;

   assign m0.gnt    = gnt0;
   assign m0.rvalid = rsp0_q.valid;
   assign m0.err    = rsp0_q.err;
   assign m0.rdata  = rsp0_q.data;

   assign m1.gnt    = gnt1;
   assign m1.rvalid = rsp1_q.valid;
   assign m1.err    = rsp1_q.err;
   assign m1.rdata  = rsp1_q.data;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_imem_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_word;
   logic [DATA_W-1:0] mem_data;

   imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

   imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .m0       (m0_if),
      .m1       (m1_if),
      .mem_addr (mem_addr),
      .mem_word (mem_word),
      .mem_data (mem_data)
   );

   always #5 clk = ~clk;

   // Memory contents; bytes past the top read back as 0xFF.
   logic [7:0] mem [DEPTH];

   // Combinational memory read port: eight little-endian bytes at mem_addr.
   always_comb begin
      mem_data = '0;
      for (int i = 0; i < 8; i++) begin
         if (int'(mem_addr) + i < DEPTH) mem_data[8*i +: 8] = mem[int'(mem_addr) + i];
         else                            mem_data[8*i +: 8] = 8'hFF;
      end
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Stimulus state per port.
   logic       req  [2];
   logic [9:0] addr [2];
   logic [1:0] word [2];

   // Reference model state.
   int          m_last;
   logic        e_rvalid [2];
   logic        e_err    [2];
   logic [63:0] e_rdata  [2];
   int          last_g;
   logic        obs_gnt0;

   task automatic apply();
      m0_if.req  = req[0];
      m0_if.addr = addr[0];
      m0_if.word = word[0];
      m1_if.req  = req[1];
      m1_if.addr = addr[1];
      m1_if.word = word[1];
   endtask

   task automatic model_reset();
      m_last = 1;
      for (int p = 0; p < 2; p++) begin
         e_rvalid[p] = 1'b0;
         e_err[p]    = 1'b0;
         e_rdata[p]  = '0;
      end
   endtask

   // One clock cycle: at the falling edge compare grant, memory drive and the
   // registered responses with the model, then advance the model and clock.
   task automatic cycle();
      int          g;
      int          nbytes;
      logic [63:0] data;
      @(negedge clk);
      g = -1;
      if (req[0] && req[1]) g = (m_last == 1) ? 0 : 1;
      else if (req[0])      g = 0;
      else if (req[1])      g = 1;
      obs_gnt0 = m0_if.gnt;

      check("m0_gnt", 64'(m0_if.gnt), 64'(g == 0));
      check("m1_gnt", 64'(m1_if.gnt), 64'(g == 1));
      check("mem_addr", 64'(mem_addr), (g >= 0) ? 64'(addr[g]) : 64'd0);
      check("mem_word", 64'(mem_word), (g >= 0) ? 64'(word[g]) : 64'd0);
      check("m0_rvalid", 64'(m0_if.rvalid), 64'(e_rvalid[0]));
      check("m1_rvalid", 64'(m1_if.rvalid), 64'(e_rvalid[1]));
      check("m0_err", 64'(m0_if.err), 64'(e_err[0]));
      check("m1_err", 64'(m1_if.err), 64'(e_err[1]));
      check("m0_rdata", m0_if.rdata, e_rdata[0]);
      check("m1_rdata", m1_if.rdata, e_rdata[1]);

      e_rvalid[0] = 1'b0;
      e_rvalid[1] = 1'b0;
      if (g >= 0) begin
         nbytes = 1 << word[g];
         e_rvalid[g] = 1'b1;
         e_err[g]    = (int'(addr[g]) + nbytes - 1) > (DEPTH - 1);
         data = '0;
         if (!e_err[g])
            for (int i = 0; i < nbytes; i++) data[8*i +: 8] = mem[int'(addr[g]) + i];
         e_rdata[g] = data;
         m_last = g;
      end
      last_g = g;
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic r, input logic [9:0] a, input logic [1:0] w);
      req[p]  = r;
      addr[p] = a;
      word[p] = w;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      set_port(0, 1'b0, '0, '0);
      set_port(1, 1'b0, '0, '0);
      apply();
      model_reset();
      last_g = -1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
      check("rst_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
      check("rst_m0_rdata", m0_if.rdata, 64'd0);
      check("rst_m1_err", 64'(m1_if.err), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single 4-byte fetch on port 0.
      mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
      set_port(0, 1'b1, 10'h010, 2'b10);
      apply();
      cycle();
      check("dir_m0_rdata", m0_if.rdata, 64'h0000_0000_4433_2211);
      check("dir_m0_rvalid", 64'(m0_if.rvalid), 64'd1);

      // Single-byte read on port 1 with all-ones upper bytes.
      mem[32] = 8'hAB;
      for (int i = 33; i < 40; i++) mem[i] = 8'hFF;
      set_port(0, 1'b0, 10'h3FF, 2'b11);
      set_port(1, 1'b1, 10'h020, 2'b00);
      apply();
      cycle();
      check("zext_m1_rdata", m1_if.rdata, 64'h0000_0000_0000_00AB);

      // Idle cycles: no grant, memory drive at zero.
      set_port(1, 1'b0, 10'h155, 2'b01);
      apply();
      cycle();
      cycle();

      // Continuous contention: expect 0,1,0,1,0,1.
      set_port(0, 1'b1, 10'h100, 2'b11);
      set_port(1, 1'b1, 10'h200, 2'b01);
      apply();
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("rr_seq_gnt0", 64'(obs_gnt0), 64'(i % 2 == 0));
      end
      set_port(0, 1'b0, 10'h0, 2'b00);
      set_port(1, 1'b0, 10'h0, 2'b00);
      apply();
      cycle();

      // Range boundary at the top of memory.
      set_port(0, 1'b1, 10'h3FC, 2'b11);
      apply();
      cycle();
      check("range_err_hi", 64'(m0_if.err), 64'd1);
      check("range_rdata_hi", m0_if.rdata, 64'd0);
      set_port(0, 1'b1, 10'h3F8, 2'b11);
      apply();
      cycle();
      check("range_err_ok", 64'(m0_if.err), 64'd0);
      set_port(0, 1'b0, 10'h0, 2'b00);
      apply();
      cycle();

      // Tie after port 0 won last: port 1 gets it, leaving last=1.
      set_port(0, 1'b1, 10'h040, 2'b01);
      set_port(1, 1'b1, 10'h080, 2'b10);
      apply();
      cycle();
      // Reset mid-cycle with a response outstanding, reqs held through it.
      check("pre_rst_m1_rvalid", 64'(m1_if.rvalid), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
      check("async_rst_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
      check("async_rst_m1_rdata", m1_if.rdata, 64'd0);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      cycle();
      check("post_rst_first_gnt", 64'(obs_gnt0), 64'd1);

      // Randomized traffic; a request stays put until it is granted.
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p] || last_g == p) begin
               req[p]  = ($urandom_range(0, 3) != 0);
               addr[p] = ($urandom_range(0, 1) == 0) ? 10'($urandom) : 10'(1016 + $urandom_range(0, 7));
               word[p] = 2'($urandom);
            end
         end
         if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, DEPTH - 1)] = 8'($urandom);
         apply();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
